// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array blocks.
//   - wl_state_e     : state encoding of the weight loader FSM.
//   - DEF_DATA_WIDTH : default weight width shared with pe_dsp and the array top.
//   - DEF_ROWS       : default number of PE rows.
//   - DEF_COLS       : default number of PE columns.
package tpu_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ROWS       = 8;
    localparam int DEF_COLS       = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT    = 3'd1,
        CAP_WAIT = 3'd2,
        CAPTURE  = 3'd3,
        DONE     = 3'd4
    } wl_state_e;

endpackage

// File: rtl/systolic_weight_loader.sv
// Producer end of the PE weight-loading interface.
// Accepts ROWS weight rows (bottom row first) over a valid/ready stream,
// shifts each one into the top of the PE weight chain, then fires a single
// capture strobe (gated by the array controller) so all PEs latch together.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wt_valid/wt_ready   : row-beat handshake from the weight buffer
//   wt_data             : one weight row, column c at [c*DATA_WIDTH +: DATA_WIDTH]
//   wt_last             : producer's end-of-tile marker (checked, not trusted)
//   capture_allow       : controller permits the capture strobe
//   err_clr             : clears the sticky err_len flag
//   weight_out          : drives weight_in of the top PE in each column
//   en_weight_pass      : shift enable for the whole weight chain
//   en_weight_capture   : one-cycle capture strobe to all PEs
//   busy                : a tile is in progress
//   load_done           : one-cycle pulse after the capture
//   err_len             : sticky, wt_last disagreed with the beat count
module systolic_weight_loader
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wt_valid,
    output logic                       wt_ready,
    input  logic [COLS*DATA_WIDTH-1:0] wt_data,
    input  logic                       wt_last,
    input  logic                       capture_allow,
    input  logic                       err_clr,
    output logic [COLS*DATA_WIDTH-1:0] weight_out,
    output logic                       en_weight_pass,
    output logic                       en_weight_capture,
    output logic                       busy,
    output logic                       load_done,
    output logic                       err_len
);

    localparam int              CNT_W    = $clog2(ROWS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROWS - 1);

    wl_state_e        state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             accept;
    logic             last_beat;
    logic             len_err;

    // Gated by rst_n so the handshake also reads 0 while reset is held.
    assign wt_ready = rst_n && ((state == IDLE) || (state == SHIFT));
    assign busy     = (state != IDLE);
    assign accept   = wt_valid && wt_ready;

    // Any mismatch between the producer's marker and our own count is an error;
    // the tile still runs to exactly ROWS beats.
    assign len_err  = accept && (wt_last != last_beat);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        last_beat = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    count_nxt = CNT_W'(1);
                    last_beat = (ROWS == 1);
                    state_nxt = (ROWS == 1) ? CAP_WAIT : SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    count_nxt = count + 1'b1;
                    if (count == LAST_CNT) begin
                        last_beat = 1'b1;
                        state_nxt = CAP_WAIT;
                    end
                end
            end
            CAP_WAIT: begin
                if (capture_allow) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = DONE;
            end
            DONE: begin
                count_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            count             <= '0;
            weight_out        <= '0;
            en_weight_pass    <= 1'b0;
            en_weight_capture <= 1'b0;
            load_done         <= 1'b0;
            err_len           <= 1'b0;
        end else begin
            state             <= state_nxt;
            count             <= count_nxt;
            // The chain only moves on an accepted beat; weight_out holds otherwise.
            if (accept) begin
                weight_out <= wt_data;
            end
            en_weight_pass    <= accept;
            // CAP_WAIT is only reached after the final beat, and that beat's pass
            // is issued in the first CAP_WAIT cycle, so pass and capture never overlap.
            en_weight_capture <= (state == CAP_WAIT) && capture_allow;
            load_done         <= (state == CAPTURE);
            // A new error takes priority over a simultaneous clear.
            if (len_err) begin
                err_len <= 1'b1;
            end else if (err_clr) begin
                err_len <= 1'b0;
            end
        end
    end

endmodule

// File: doc/systolic_weight_loader.md
Name: systolic_weight_loader

Overview:
- Producer end of the PE weight-loading interface: drives `weight_in`, `en_weight_pass` and `en_weight_capture` into the top of every column of the ROWS x COLS `pe_dsp` array.
- Accepts one weight row per valid/ready beat from the weight buffer and shifts ROWS rows down the pass chain.
- Then issues a single capture pulse so that every PE latches its weight at the same time. The capture pulse is gated by the array controller.

Parameters:
- DATA_WIDTH, 8, width of one weight.
- ROWS, 8, PE rows; one tile is ROWS beats.
- COLS, 8, PE columns; one beat carries COLS weights.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wt_valid  in  1  a row beat is offered.
- wt_ready  out  1  loader accepts the beat this cycle.
- wt_data  in  COLS*DATA_WIDTH  one weight row; column c is at bits [c*DATA_WIDTH +: DATA_WIDTH].
- wt_last  in  1  producer marks the final beat of the tile.
- capture_allow  in  1  controller permits the capture (array not computing).
- err_clr  in  1  clears err_len.
- weight_out  out  COLS*DATA_WIDTH  drives `weight_in` of the top PE in each column.
- en_weight_pass  out  1  shift enable for the whole weight chain.
- en_weight_capture  out  1  one-cycle capture strobe to all PEs.
- busy  out  1  a tile is in progress.
- load_done  out  1  one-cycle pulse after the capture.
- err_len  out  1  sticky: wt_last did not agree with the beat count.

Behaviour:
- Reset values: every output is 0; state = IDLE; beat count = 0.
- Outputs weight_out, en_weight_pass, en_weight_capture, load_done and err_len are registered.
- Beat order: the first beat holds the bottom row (ROWS-1), the last beat holds row 0.
- A beat is accepted when wt_valid && wt_ready in cycle t. At t+1: weight_out = that wt_data and en_weight_pass = 1.
- In any cycle with no accepted beat, en_weight_pass = 0 and weight_out holds its value. The chain does not move during stalls.
- FSM:
  - IDLE: wt_ready = 1, busy = 0. An accepted beat sets count = 1 and moves to SHIFT; if ROWS == 1 it goes directly to CAP_WAIT.
  - SHIFT: wt_ready = 1, busy = 1. Each accepted beat does count++. The beat with count == ROWS-1 (the ROWS-th beat) moves to CAP_WAIT.
  - CAP_WAIT: wt_ready = 0. This state lasts at least one cycle, during which the final pass is issued. While capture_allow = 1 the FSM goes to CAPTURE; otherwise it holds with en_weight_pass = 0.
  - CAPTURE: en_weight_capture = 1 for exactly one cycle, then DONE.
  - DONE: load_done = 1 for one cycle, count = 0, then IDLE.
- Minimum latency: last beat accepted at t → final pass at t+1 → capture at t+2 → load_done at t+3. The next tile may be accepted at t+4.
- Length check at each accepted beat:
  - wt_last = 1 before the ROWS-th beat sets err_len.
  - wt_last = 0 on the ROWS-th beat sets err_len.
  - In both cases the tile still completes after exactly ROWS beats. There is no early termination.
- err_len is sticky. err_clr clears it. If err_clr and a new error occur in the same cycle, the error wins.
- en_weight_pass and en_weight_capture are never high in the same cycle.
- Reset asserted mid-tile: all outputs go to 0 immediately. The partially shifted chain is not captured, and the PEs keep their previously captured weights.
- No arithmetic; count width is $clog2(ROWS+1).

Decomposition:
- The shared package `tpu_pkg` holds:
  - the loader state enum typedef `wl_state_e` (IDLE, SHIFT, CAP_WAIT, CAPTURE, DONE);
  - the default DATA_WIDTH, ROWS and COLS constants, shared with `pe_dsp` and the array top.
- No sub-module. The block is a single FSM plus counter and output registers.

Test Plan:
- ROWS=4, COLS=2, rows 0x0102, 0x0304, 0x0506, 0x0708 sent back-to-back, capture_allow = 1 → en_weight_pass high for 4 consecutive cycles, en_weight_capture 1 cycle later, load_done 1 cycle after that. A 4x2 `pe_dsp` chain model must end with row0 weights = 0x07,0x08 and row3 weights = 0x01,0x02.
- Same tile with wt_valid deasserted for 3 cycles after beat 2 → en_weight_pass low during the gap and weight_out holds 0x0304. Captured weights are identical to the previous scenario.
- capture_allow held 0 for 10 cycles after the last beat → wt_ready = 0, no pass, no capture, busy = 1. Capture occurs 1 cycle after capture_allow rises.
- wt_last asserted on beat 2 of 4 → err_len = 1 from the next cycle. 4 passes plus capture still occur. err_clr pulse → err_len = 0.
- rst_n pulsed low after beat 2 → all outputs 0 asynchronously and no capture. A following full tile loads correctly.
- Two tiles back-to-back with wt_valid held high → wt_ready low for exactly 3 cycles between tiles (CAP_WAIT, CAPTURE, DONE), and 2 load_done pulses.
